counter_snapshot_serializer: RTL and testbench

Downstream consumer of the 128-bit free-running counter. On a trigger pulse it captures the counter value into a shadow register and streams it out as WORD_W-bit beats over a valid/ready handshake, least-significant word first. It decouples the wide counter from narrow readout logic, such as a 32-bit debug bus or a trace FIFO, without stalling the counter.

---
 rtl/counter_snapshot_serializer.sv | 147 ++++++++++++++
 tb/tb_counter_snapshot_serializer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_snapshot_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : counter_snapshot_serializer
//  Purpose  : Captures a wide free-running counter value into a shadow
//             register on a trigger pulse, then streams it out as WORD_W-bit
//             beats over a valid/ready handshake, least-significant word
//             first. The counter itself is never stalled.
//
//  Optional : `define SNAPSHOT_CHECKSUM_EN appends one extra beat carrying
//             the XOR of all data words. dout_last then marks that beat.
//             Without the macro no checksum logic is built.
//
//  Ports    : clk         in   single clock, rising edge
//             reset       in   synchronous, active-high reset
//             count       in   live counter value (COUNT_W bits)
//             trigger     in   single-cycle capture request
//             busy        out  high while a snapshot is being streamed
//             dout        out  current beat data (WORD_W bits)
//             dout_valid  out  beat valid
//             dout_ready  in   sink ready
//             dout_last   out  final beat of a snapshot
//             overrun     out  sticky: a trigger was dropped
//
//  Revision : 1.0  initial release
// ============================================================================
module counter_snapshot_serializer #(
  parameter int COUNT_W = 128,  // must be an integer multiple of WORD_W
  parameter int WORD_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COUNT_W-1:0] count,
  input  logic               trigger,
  output logic               busy,
  output logic [WORD_W-1:0]  dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               dout_last,
  output logic               overrun
);

  localparam int c_NUM_WORDS = COUNT_W / WORD_W;
`ifdef SNAPSHOT_CHECKSUM_EN
  localparam int c_NUM_BEATS = c_NUM_WORDS + 1;
`else
  localparam int c_NUM_BEATS = c_NUM_WORDS;
`endif
  // One spare code point keeps the width sane even for a single-beat build.
  localparam int c_IDX_W = $clog2(c_NUM_BEATS + 1);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NUM_BEATS - 1);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_SEND = 1'b1;

  logic [0:0]         r_state;
  logic [c_IDX_W-1:0] r_idx;
  logic [COUNT_W-1:0] r_shadow;
  logic               r_overrun;

  logic               w_send;
  logic               w_hs;
  logic               w_last;
  logic               w_last_hs;
  logic               w_capture;
  logic               w_drop;
  logic [WORD_W-1:0]  w_beat;

`ifdef SNAPSHOT_CHECKSUM_EN
  logic [WORD_W-1:0]  r_csum;
  logic [WORD_W-1:0]  w_count_xor;

  // Checksum is folded from the live count in the capture cycle, so it is
  // ready alongside the shadow and costs no extra beat latency.
  always_comb begin
    w_count_xor = '0;
    for (int i = 0; i < c_NUM_WORDS; i++) begin
      w_count_xor = w_count_xor ^ count[i*WORD_W +: WORD_W];
    end
  end
`endif

  assign w_send    = (r_state == c_SEND);
  assign w_hs      = w_send && dout_ready;
  assign w_last    = (r_idx == c_LAST_IDX);
  assign w_last_hs = w_hs && w_last;

  // A trigger is accepted when idle, or when it lands exactly on the
  // completing handshake of the final beat (back-to-back, no bubble).
  assign w_capture = trigger && (!w_send || w_last_hs);
  assign w_drop    = trigger && w_send && !w_last_hs;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= c_IDLE;
      r_idx     <= '0;
      r_shadow  <= '0;
      r_overrun <= 1'b0;
`ifdef SNAPSHOT_CHECKSUM_EN
      r_csum    <= '0;
`endif
    end else begin
      if (w_capture) begin
        r_shadow <= count;
        r_idx    <= '0;
        r_state  <= c_SEND;
`ifdef SNAPSHOT_CHECKSUM_EN
        r_csum   <= w_count_xor;
`endif
      end else if (w_hs) begin
        if (w_last) begin
          r_state <= c_IDLE;
          r_idx   <= '0;
        end else begin
          r_idx   <= r_idx + 1'b1;
        end
      end

      if (w_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // Beat select: a registered index picking from registered shadow, so no
  // path exists from dout_ready into dout/dout_valid/dout_last.
  always_comb begin
    w_beat = '0;
    for (int i = 0; i < c_NUM_WORDS; i++) begin
      if (r_idx == c_IDX_W'(i)) begin
        w_beat = r_shadow[i*WORD_W +: WORD_W];
      end
    end
`ifdef SNAPSHOT_CHECKSUM_EN
    if (r_idx == c_LAST_IDX) begin
      w_beat = r_csum;
    end
`endif
  end

  assign busy       = w_send;
  assign dout_valid = w_send;
  assign dout       = w_send ? w_beat : '0;
  assign dout_last  = w_send && w_last;
  assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_counter_snapshot_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter_snapshot_serializer
//  Purpose  : Self-checking bench for counter_snapshot_serializer: a table of
//             directed vectors, hand-written multi-cycle sequences, and a
//             randomized run against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_counter_snapshot_serializer;

  localparam logic [127:0] C1 = 128'h00000004_00000003_00000002_00000001;
  localparam logic [127:0] C8 = 128'h88888888_88888888_88888888_88888888;
`ifdef SNAPSHOT_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic [127:0] count;
  logic         trigger;
  logic         busy;
  logic [31:0]  dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         dout_last;
  logic         overrun;

  counter_snapshot_serializer #(
    .COUNT_W (128),
    .WORD_W  (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .count      (count),
    .trigger    (trigger),
    .busy       (busy),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic ev, input logic [31:0] ed,
                           input logic el, input logic eo);
    check({tag, ".valid"},   {31'b0, dout_valid}, {31'b0, ev});
    check({tag, ".busy"},    {31'b0, busy},       {31'b0, ev});
    check({tag, ".dout"},    dout,                ed);
    check({tag, ".last"},    {31'b0, dout_last},  {31'b0, el});
    check({tag, ".overrun"}, {31'b0, overrun},    {31'b0, eo});
  endtask

  // Drive one cycle of inputs, let the edge happen, settle just after it.
  task automatic apply(input logic r, input logic t, input logic rd, input logic [127:0] c);
    reset      = r;
    trigger    = t;
    dout_ready = rd;
    count      = c;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic         rst;
    logic         trig;
    logic         rdy;
    logic [127:0] cnt;
    logic         ev;
    logic [31:0]  ed;
    logic         el;
    logic         eo;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic t, input logic rd, input logic [127:0] c,
                              input logic ev, input logic [31:0] ed, input logic el, input logic eo);
    vec_t v;
    v.rst = r; v.trig = t; v.rdy = rd; v.cnt = c;
    v.ev = ev; v.ed = ed; v.el = el; v.eo = eo;
    vecs.push_back(v);
  endfunction

  // ---------------- reference model ----------------
  // Pending beats of the current snapshot; busy whenever non-empty.
  logic [31:0] m_q[$];
  logic        m_ovr;

  task automatic model_load(input logic [127:0] c);
    logic [31:0] x;
    x = '0;
    for (int i = 0; i < 4; i++) begin
      m_q.push_back(c[i*32 +: 32]);
      x = x ^ c[i*32 +: 32];
    end
    if (CS) m_q.push_back(x);
  endtask

  task automatic model_step(input logic r, input logic t, input logic rd, input logic [127:0] c);
    bit was_busy;
    bit hs;
    if (r) begin
      m_q.delete();
      m_ovr = 1'b0;
    end else begin
      was_busy = (m_q.size() > 0);
      hs = was_busy && rd;
      if (hs) void'(m_q.pop_front());
      if (t) begin
        if (!was_busy || (hs && m_q.size() == 0)) model_load(c);
        else m_ovr = 1'b1;
      end
    end
  endtask

  initial begin
    reset = 1'b1; trigger = 1'b0; dout_ready = 1'b0; count = '0;
    m_ovr = 1'b0;

    // Basic snapshot with the reset state checked first.
    add(1'b1, 1'b0, 1'b0, '0, 1'b0, 32'd0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, C1, 1'b1, 32'd1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, C8, 1'b1, 32'd2, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, C8, 1'b1, 32'd3, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, C8, 1'b1, 32'd4, !CS,  1'b0);
    if (CS) add(1'b0, 1'b0, 1'b1, C8, 1'b1, 32'd4, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, C8, 1'b0, 32'd0, 1'b0, 1'b0);
    // Backpressure: ready toggling, each word holds while stalled.
    add(1'b0, 1'b1, 1'b0, C1, 1'b1, 32'd1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, C8, 1'b1, 32'd1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, C8, 1'b1, 32'd2, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, C8, 1'b1, 32'd2, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, C8, 1'b1, 32'd3, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, C8, 1'b1, 32'd3, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, C8, 1'b1, 32'd4, !CS,  1'b0);
    add(1'b0, 1'b0, 1'b0, C8, 1'b1, 32'd4, !CS,  1'b0);
    if (CS) begin
      add(1'b0, 1'b0, 1'b1, C8, 1'b1, 32'd4, 1'b1, 1'b0);
      add(1'b0, 1'b0, 1'b0, C8, 1'b1, 32'd4, 1'b1, 1'b0);
    end
    add(1'b0, 1'b0, 1'b1, C8, 1'b0, 32'd0, 1'b0, 1'b0);
    // Overrun: second trigger two cycles later is dropped, stream intact.
    add(1'b0, 1'b1, 1'b1, C1, 1'b1, 32'd1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, C8, 1'b1, 32'd2, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, C8, 1'b1, 32'd3, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, C8, 1'b1, 32'd4, !CS,  1'b1);
    if (CS) add(1'b0, 1'b0, 1'b1, C8, 1'b1, 32'd4, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b1, C8, 1'b0, 32'd0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, C8, 1'b0, 32'd0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, C8, 1'b0, 32'd0, 1'b0, 1'b0);
    // Reset/trigger collision: reset wins, nothing captured.
    add(1'b1, 1'b1, 1'b1, C1, 1'b0, 32'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, C1, 1'b0, 32'd0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst, vecs[i].trig, vecs[i].rdy, vecs[i].cnt);
      check_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].el, vecs[i].eo);
    end

    // Back-to-back: trigger on the last-beat handshake, no idle cycle.
    apply(1'b0, 1'b1, 1'b1, C1);
    check_out("b2b.w0", 1'b1, 32'd1, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b1, C1);
    apply(1'b0, 1'b0, 1'b1, C1);
    apply(1'b0, 1'b0, 1'b1, C1);
    check_out("b2b.w3", 1'b1, 32'd4, !CS, 1'b0);
`ifdef SNAPSHOT_CHECKSUM_EN
    apply(1'b0, 1'b0, 1'b1, C1);
    check_out("b2b.cs", 1'b1, 32'd4, 1'b1, 1'b0);
`endif
    apply(1'b0, 1'b1, 1'b1, C8);
    check_out("b2b.n0", 1'b1, 32'h88888888, 1'b0, 1'b0);
    for (int k = 1; k < 4; k++) begin
      apply(1'b0, 1'b0, 1'b1, C1);
      check_out($sformatf("b2b.n%0d", k), 1'b1, 32'h88888888, (k == 3) && !CS, 1'b0);
    end
`ifdef SNAPSHOT_CHECKSUM_EN
    apply(1'b0, 1'b0, 1'b1, C1);
    check_out("b2b.ncs", 1'b1, 32'h0, 1'b1, 1'b0);
`endif
    apply(1'b0, 1'b0, 1'b1, C1);
    check_out("b2b.idle", 1'b0, 32'd0, 1'b0, 1'b0);

    // Mid-snapshot reset after two beats, with overrun set beforehand.
    apply(1'b0, 1'b1, 1'b1, C1);
    apply(1'b0, 1'b0, 1'b1, C8);
    apply(1'b0, 1'b1, 1'b1, C8);
    check_out("mid.pre", 1'b1, 32'd3, 1'b0, 1'b1);
    apply(1'b1, 1'b0, 1'b1, C8);
    check_out("mid.rst", 1'b0, 32'd0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b0, C1);
    check_out("mid.re0", 1'b1, 32'd1, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b1, C8);
    check_out("mid.re1", 1'b1, 32'd2, 1'b0, 1'b0);

    // Randomized run against the reference model.
    model_step(1'b1, 1'b0, 1'b0, '0);
    apply(1'b1, 1'b0, 1'b0, '0);
    for (int n = 0; n < 3000; n++) begin
      logic         r, t, rd;
      logic [127:0] c;
      logic         ev;
      r  = ($urandom_range(0, 149) == 0);
      t  = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 9) < 7);
      c  = {$urandom(), $urandom(), $urandom(), $urandom()};
      model_step(r, t, rd, c);
      apply(r, t, rd, c);
      ev = (m_q.size() > 0);
      check_out($sformatf("rnd%0d", n), ev, ev ? m_q[0] : 32'd0, m_q.size() == 1, m_ovr);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
